apb_console_writer: RTL and testbench
=====================================

# apb_console_writer

Byte-stream to APB write bridge that feeds the simulation console slave (`uart_console`). Software-model or testbench producers push characters through a valid/ready interface. The block buffers them in a small FIFO and issues one APB write per byte to the console address, so characters reach the console in order. It sits directly upstream of the console on the APB bus and is the only master of that bus segment.

## Interface
- `CONSOLE_ADDR`, default 32'h1000_0000: address driven on every write; must match the console's decode address.
- `FIFO_DEPTH`, default 8: byte buffer depth; power of two, ≥2.
- `clk_i` input 1: single clock; all logic on rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `byte_valid_i` input 1: producer has a byte.
- `byte_data_i` input 8: character to print.
- `byte_ready_o` output 1: FIFO can accept; a byte transfers on `byte_valid_i & byte_ready_o` at a rising edge.
- `psel_o` output 1: APB select.
- `penable_o` output 1: APB enable (access phase).
- `pwrite_o` output 1: APB write; high whenever `psel_o` is high.
- `paddr_o` output 32: `CONSOLE_ADDR` while `psel_o`, else 0.
- `pwdata_o` output 32: {24'h0, byte} while `psel_o`, else 0.
- `pready_i` input 1: APB ready; used only with `APB_CONSOLE_PREADY_EN`.
- `level_o` output $clog2(FIFO_DEPTH)+1: FIFO occupancy, excluding the byte in flight once popped.
- `busy_o` output 1: FIFO non-empty or transfer in progress.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: `psel_o`=0. If the FIFO is non-empty, go to SETUP and register the FIFO head into the write-data register.
- SETUP: `psel_o`=1, `penable_o`=0. Always go to ACCESS next.
- ACCESS: `psel_o`=1, `penable_o`=1. On completion, pop the FIFO.
  - Completion is every ACCESS cycle without the macro; with the macro it is `pready_i`=1.
  - After completion, if another byte remains after the pop, go directly to SETUP with the new head registered; otherwise go to IDLE.
- `paddr_o` and `pwdata_o` stay stable from SETUP through the completing ACCESS cycle.
- The FIFO pops only on completion. The byte under transfer stays at the FIFO head and counts in `level_o` until popped.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- `byte_ready_o` = !full & !rst_i.
  - There is no combinational path from `pready_i` or pop to `byte_ready_o`. When full, a same-cycle pop does not admit a push.
- Pointers wrap modulo `FIFO_DEPTH`. The full/empty distinction uses an extra pointer bit.
- `byte_valid_i` with `byte_ready_o`=0 is stalled. Bytes are never dropped.

## Timing
- Reset values: `psel_o`, `penable_o`, `pwrite_o`=0; `paddr_o`, `pwdata_o`=0; `level_o`=0; `busy_o`=0; `byte_ready_o`=0 during reset, 1 on the first cycle after it.
- Reset mid-transfer: on the reset edge the FSM returns to IDLE and the FIFO empties. Queued bytes are discarded and the APB outputs are 0 in the next cycle.
- Latency with an empty FIFO: byte accepted at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2. Without wait states the pop happens at edge N+3.
- Throughput: one byte per 2 cycles with no wait states. There are no idle cycles between back-to-back transfers.
- `busy_o` is registered: high from the cycle after the first accept until the cycle after the last completion.

## Configuration
- `APB_CONSOLE_PREADY_EN` defined: ACCESS holds until `pready_i`=1, so wait states are unbounded.
- `APB_CONSOLE_PREADY_EN` undefined: `pready_i` is ignored and ACCESS lasts exactly one cycle, matching the console, which has no ready.

## Structure
- Package `apb_console_pkg`:
  - state enum typedef `console_state_e` (IDLE/SETUP/ACCESS)
  - `CONSOLE_ADDR_DEFAULT`
  - `APB_AW`=32, `APB_DW`=32
- Sub-module `console_fifo`: synchronous FIFO with push, pop, full, empty and level. The FSM stays in the top.

## Test plan
- Push 0x41 at edge 0, empty FIFO → `psel_o`=1 in cycle 1 and `penable_o`=1 in cycle 2, with `paddr_o`=0x1000_0000 and `pwdata_o`=0x0000_0041; the console prints "A"; `busy_o` drops after completion.
- Push 16 bytes "Hello, console!\n" back-to-back, FIFO_DEPTH=4 → `byte_ready_o` deasserts while full; the console prints the exact string; 16 transfers at 2 cycles each with no IDLE gaps.
- Macro on, `pready_i` held low for 3 ACCESS cycles → ACCESS lasts 4 cycles; `paddr_o`/`pwdata_o` stable; `level_o` decrements only on the `pready_i` cycle.
- Macro off, `pready_i` tied 0 → each transfer completes in 2 cycles regardless.
- `rst_i` pulsed during ACCESS with 3 bytes queued → next cycle `psel_o`=0, `level_o`=0, `busy_o`=0; no further writes until new pushes arrive.
- FIFO full with a simultaneous completion and `byte_valid_i`=1 → push refused that cycle and accepted the next; byte order is preserved.

Source files
------------

// File: rtl/apb_console_pkg.sv
// Shared types and constants for the APB console writer.
// The top module reads the optional macro APB_CONSOLE_PREADY_EN to honour pready_i.
package apb_console_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  localparam logic [APB_AW-1:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } console_state_e;

  // The console only looks at the low byte; the upper write-data bits are zero.
  function automatic logic [APB_DW-1:0] apb_wdata(input logic [7:0] ch);
    return {{(APB_DW-8){1'b0}}, ch};
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous byte FIFO for the console writer. Pointers carry one extra bit so
// that full and empty can be told apart; DEPTH must be a power of two, >= 2.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               head_data,
  output logic [7:0]               next_data
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW:0]   wr_ptr_reg;
  logic [PW:0]   rd_ptr_reg;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] rd_addr;
  logic [PW-1:0] rd_addr_next;

  assign wr_addr      = wr_ptr_reg[PW-1:0];
  assign rd_addr      = rd_ptr_reg[PW-1:0];
  assign rd_addr_next = rd_addr + PW'(1);

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_addr == rd_addr);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // next_data lets the master reload its write register on the same edge it pops.
  assign head_data = mem[rd_addr];
  assign next_data = mem[rd_addr_next];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_addr] <= push_data;
    end
  end

endmodule

// File: rtl/apb_console_writer.sv
// Byte-stream to APB write bridge feeding the console slave, one write per byte.
// Optional macro APB_CONSOLE_PREADY_EN: ACCESS waits for pready_i; otherwise it lasts one cycle.
module apb_console_writer
  import apb_console_pkg::*;
#(
  parameter logic [APB_AW-1:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter int                FIFO_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          byte_valid_i,
  input  logic [7:0]                    byte_data_i,
  output logic                          byte_ready_o,
  output logic                          psel_o,
  output logic                          penable_o,
  output logic                          pwrite_o,
  output logic [APB_AW-1:0]             paddr_o,
  output logic [APB_DW-1:0]             pwdata_o,
  input  logic                          pready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  console_state_e state_reg;
  console_state_e state_next;
  logic [7:0]     wdata_reg;
  logic [7:0]     wdata_next;
  logic           busy_reg;
  logic           busy_next;

  logic           push;
  logic           pop;
  logic           complete;
  logic           fifo_full;
  logic           fifo_empty;
  logic [LW-1:0]  fifo_level;
  logic [LW-1:0]  level_after;
  logic [7:0]     head_data;
  logic [7:0]     next_data;

  // Ready depends only on the registered full flag, never on a same-cycle pop.
  assign byte_ready_o = !fifo_full && !rst_i;
  assign push         = byte_valid_i && byte_ready_o;

`ifdef APB_CONSOLE_PREADY_EN
  assign complete = (state_reg == ACCESS) && pready_i;
`else
  logic unused_pready;
  assign unused_pready = pready_i;
  assign complete      = (state_reg == ACCESS);
`endif

  assign pop = complete;

  console_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .srst      (rst_i),
    .push      (push),
    .push_data (byte_data_i),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head_data (head_data),
    .next_data (next_data)
  );

  always_comb begin
    state_next = state_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = SETUP;
          wdata_next = head_data;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (complete) begin
          // The completing byte is still at the head, so more than one queued means another remains.
          if (fifo_level > LW'(1)) begin
            state_next = SETUP;
            wdata_next = next_data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every queued byte stays in the FIFO until popped, so occupancy alone decides busy.
  assign level_after = fifo_level + LW'(push) - LW'(pop);
  assign busy_next   = (state_next != IDLE) || (level_after != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      wdata_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wdata_reg <= wdata_next;
      busy_reg  <= busy_next;
    end
  end

  assign psel_o    = (state_reg != IDLE);
  assign penable_o = (state_reg == ACCESS);
  assign pwrite_o  = psel_o;
  assign paddr_o   = psel_o ? CONSOLE_ADDR : '0;
  assign pwdata_o  = psel_o ? apb_wdata(wdata_reg) : '0;
  assign level_o   = fifo_level;
  assign busy_o    = busy_reg;

endmodule

// File: tb/tb_apb_console_writer.sv
// Self-checking bench for apb_console_writer (FIFO_DEPTH=4); the expected stream is
// a queue of accepted-but-not-yet-written bytes. Honours APB_CONSOLE_PREADY_EN.
module tb_apb_console_writer;

  localparam int          DEPTH = 4;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] ADDR  = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [31:0]   paddr_o;
  logic [31:0]   pwdata_o;
  logic          pready_i;
  logic [LW-1:0] level_o;
  logic          busy_o;

  always #5 clk = ~clk;

  apb_console_writer #(
    .CONSOLE_ADDR(ADDR),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pready_i     (pready_i),
    .level_o      (level_o),
    .busy_o       (busy_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: bytes accepted and not yet written, in order.
  logic [7:0] exp_q[$];
  logic [7:0] acc_log[$];
  logic [7:0] console_log[$];
  int         comp_cyc[$];

  logic       pend_rst  = 1'b0;
  logic       pend_push = 1'b0;
  logic       pend_pop  = 1'b0;
  logic [7:0] pend_data = 8'h00;

  // Decide at the falling edge what the next rising edge does; apply it at that edge.
  always @(negedge clk) begin
    pend_rst  = rst_i;
    pend_push = byte_valid_i && byte_ready_o && !rst_i;
    pend_data = byte_data_i;
`ifdef APB_CONSOLE_PREADY_EN
    pend_pop  = psel_o && penable_o && pready_i && !rst_i;
`else
    pend_pop  = psel_o && penable_o && !rst_i;
`endif
    if (pend_pop) begin
      console_log.push_back(pwdata_o[7:0]);
      comp_cyc.push_back(cyc);
      $display("apb write cycle=%0d addr=%08h data=%08h", cyc, paddr_o, pwdata_o);
    end
    if (pend_push) acc_log.push_back(byte_data_i);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pend_rst) begin
      exp_q.delete();
    end else begin
      if (pend_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pend_push) exp_q.push_back(pend_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    console_log.delete();
    comp_cyc.delete();
    acc_log.delete();
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy_o && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL %s_drain: busy=%b queued=%0d required idle", name, busy_o, exp_q.size()); end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (byte_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", byte_ready_o); end
    checks++; if (psel_o !== 1'b0)       begin failures++; $display("FAIL reset_psel: got %b required 0", psel_o); end
    checks++; if (penable_o !== 1'b0)    begin failures++; $display("FAIL reset_penable: got %b required 0", penable_o); end
    checks++; if (pwrite_o !== 1'b0)     begin failures++; $display("FAIL reset_pwrite: got %b required 0", pwrite_o); end
    checks++; if (paddr_o !== 32'h0)     begin failures++; $display("FAIL reset_paddr: got %h required 0", paddr_o); end
    checks++; if (pwdata_o !== 32'h0)    begin failures++; $display("FAIL reset_pwdata: got %h required 0", pwdata_o); end
    checks++; if (level_o !== '0)        begin failures++; $display("FAIL reset_level: got %0d required 0", level_o); end
    checks++; if (busy_o !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (byte_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b required 1", byte_ready_o); end
  endtask

  task automatic test_single();
    clear_logs();
    tick();
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h41;
    tick();
    byte_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (psel_o !== 1'b0)  begin failures++; $display("FAIL single_c0_psel: got %b required 0", psel_o); end
    checks++; if (level_o !== LW'(1)) begin failures++; $display("FAIL single_c0_level: got %0d required 1", level_o); end
    checks++; if (busy_o !== 1'b1)  begin failures++; $display("FAIL single_c0_busy: got %b required 1", busy_o); end
    @(negedge clk);
    checks++; if (psel_o !== 1'b1 || penable_o !== 1'b0 || pwrite_o !== 1'b1)
      begin failures++; $display("FAIL single_setup: psel=%b penable=%b pwrite=%b required 1 0 1", psel_o, penable_o, pwrite_o); end
    checks++; if (paddr_o !== ADDR)        begin failures++; $display("FAIL single_setup_addr: got %h required %h", paddr_o, ADDR); end
    checks++; if (pwdata_o !== 32'h41)     begin failures++; $display("FAIL single_setup_data: got %h required 00000041", pwdata_o); end
    @(negedge clk);
    checks++; if (psel_o !== 1'b1 || penable_o !== 1'b1)
      begin failures++; $display("FAIL single_access: psel=%b penable=%b required 1 1", psel_o, penable_o); end
    checks++; if (paddr_o !== ADDR || pwdata_o !== 32'h41)
      begin failures++; $display("FAIL single_access_bus: addr=%h data=%h required %h 00000041", paddr_o, pwdata_o, ADDR); end
    @(negedge clk);
    checks++; if (psel_o !== 1'b0 || level_o !== '0 || busy_o !== 1'b0)
      begin failures++; $display("FAIL single_done: psel=%b level=%0d busy=%b required 0 0 0", psel_o, level_o, busy_o); end
    checks++; if (paddr_o !== 32'h0 || pwdata_o !== 32'h0)
      begin failures++; $display("FAIL single_idle_bus: addr=%h data=%h required 0 0", paddr_o, pwdata_o); end
    checks++; if (console_log.size() != 1 || console_log[0] !== 8'h41)
      begin failures++; $display("FAIL single_console: count=%0d required 1 byte 41", console_log.size()); end
  endtask

  task automatic test_hello();
    string msg;
    int    i = 0;
    bit    saw_full = 1'b0;
    logic  r;
    msg = "Hello, console!\n";
    clear_logs();
`ifdef APB_CONSOLE_PREADY_EN
    pready_i = 1'b1;
`else
    pready_i = 1'b0;
`endif
    tick();
    byte_valid_i = 1'b1;
    byte_data_i  = msg[0];
    for (int c = 0; c < 200 && i < 16; c++) begin
      @(negedge clk);
      r = byte_ready_o;
      checks++; if (r !== (exp_q.size() < DEPTH))
        begin failures++; $display("FAIL hello_ready: got %b with %0d queued", r, exp_q.size()); end
      checks++; if (level_o !== LW'(exp_q.size()))
        begin failures++; $display("FAIL hello_level: got %0d required %0d", level_o, exp_q.size()); end
      if (r !== 1'b1) saw_full = 1'b1;
      tick();
      if (r === 1'b1) begin
        i++;
        if (i < 16) byte_data_i = msg[i];
      end
    end
    byte_valid_i = 1'b0;
    checks++; if (i != 16) begin failures++; $display("FAIL hello_push_timeout: pushed %0d required 16", i); end
    drain("hello");
    checks++; if (!saw_full) begin failures++; $display("FAIL hello_backpressure: ready never dropped, required a full stall"); end
    checks++; if (console_log.size() != 16)
      begin failures++; $display("FAIL hello_count: got %0d required 16", console_log.size()); end
    for (int k = 0; k < 16 && k < console_log.size(); k++) begin
      checks++; if (console_log[k] !== msg[k])
        begin failures++; $display("FAIL hello_char%0d: got %h required %h", k, console_log[k], msg[k]); end
    end
    for (int k = 1; k < comp_cyc.size(); k++) begin
      checks++; if (comp_cyc[k] - comp_cyc[k-1] != 2)
        begin failures++; $display("FAIL hello_spacing%0d: got %0d cycles required 2", k, comp_cyc[k] - comp_cyc[k-1]); end
    end
  endtask

`ifdef APB_CONSOLE_PREADY_EN
  task automatic test_wait_states();
    bit found = 1'b0;
    clear_logs();
    pready_i = 1'b0;
    tick();
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h57;
    tick();
    byte_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (penable_o === 1'b1) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL wait_access_timeout: penable=%b required 1", penable_o); end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) pready_i = 1'b1;
      @(negedge clk);
      checks++; if (penable_o !== 1'b1 || level_o !== LW'(1))
        begin failures++; $display("FAIL wait_hold%0d: penable=%b level=%0d required 1 1", k, penable_o, level_o); end
      checks++; if (paddr_o !== ADDR || pwdata_o !== 32'h57)
        begin failures++; $display("FAIL wait_stable%0d: addr=%h data=%h required %h 00000057", k, paddr_o, pwdata_o, ADDR); end
      tick();
    end
    pready_i = 1'b0;
    @(negedge clk);
    checks++; if (psel_o !== 1'b0 || level_o !== '0 || busy_o !== 1'b0)
      begin failures++; $display("FAIL wait_done: psel=%b level=%0d busy=%b required 0 0 0", psel_o, level_o, busy_o); end
    checks++; if (console_log.size() != 1 || console_log[0] !== 8'h57)
      begin failures++; $display("FAIL wait_console: count=%0d required 1 byte 57", console_log.size()); end
  endtask
`else
  task automatic test_pready_ignored();
    bit found = 1'b0;
    clear_logs();
    pready_i = 1'b0;
    tick();
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h4E;
    tick();
    byte_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (penable_o === 1'b1) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL ignore_access_timeout: penable=%b required 1", penable_o); end
    @(negedge clk);
    checks++; if (level_o !== LW'(1)) begin failures++; $display("FAIL ignore_level: got %0d required 1", level_o); end
    tick();
    @(negedge clk);
    checks++; if (psel_o !== 1'b0 || level_o !== '0)
      begin failures++; $display("FAIL ignore_done: psel=%b level=%0d required 0 0", psel_o, level_o); end
    checks++; if (console_log.size() != 1 || console_log[0] !== 8'h4E)
      begin failures++; $display("FAIL ignore_console: count=%0d required 1 byte 4e", console_log.size()); end
  endtask
`endif

  task automatic test_full_pop();
    logic [7:0] b[8];
    int         i = 0;
    int         probe = 0;
    logic       r;
    for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
    clear_logs();
    pready_i = 1'b1;
    tick();
    byte_valid_i = 1'b1;
    byte_data_i  = b[0];
    for (int c = 0; c < 100 && i < 8; c++) begin
      @(negedge clk);
      r = byte_ready_o;
      if (probe == 2) begin
        checks++; if (level_o !== LW'(4)) begin failures++; $display("FAIL fullpop_accept_level: got %0d required 4", level_o); end
        probe = 3;
      end
      if (probe == 1) begin
        checks++; if (level_o !== LW'(3)) begin failures++; $display("FAIL fullpop_refused_level: got %0d required 3", level_o); end
        checks++; if (r !== 1'b1) begin failures++; $display("FAIL fullpop_ready_after: got %b required 1", r); end
        probe = 2;
      end
      if (probe == 0 && r === 1'b0 && penable_o === 1'b1) begin
        checks++; if (level_o !== LW'(4)) begin failures++; $display("FAIL fullpop_full_level: got %0d required 4", level_o); end
        probe = 1;
      end
      tick();
      if (r === 1'b1) begin
        i++;
        if (i < 8) byte_data_i = b[i];
      end
    end
    byte_valid_i = 1'b0;
    checks++; if (probe != 3) begin failures++; $display("FAIL fullpop_scenario: reached step %0d required 3", probe); end
    drain("fullpop");
    checks++; if (console_log.size() != 8) begin failures++; $display("FAIL fullpop_count: got %0d required 8", console_log.size()); end
    for (int k = 0; k < 8 && k < console_log.size(); k++) begin
      checks++; if (console_log[k] !== b[k])
        begin failures++; $display("FAIL fullpop_order%0d: got %h required %h", k, console_log[k], b[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int psel_seen = 0;
    clear_logs();
    pready_i = 1'b1;
    tick();
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h11;
    tick();
    byte_data_i  = 8'h22;
    tick();
    byte_data_i  = 8'h33;
    tick();
    byte_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (penable_o === 1'b1) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found || level_o !== LW'(3))
      begin failures++; $display("FAIL rstmid_setup: access=%b level=%0d required 1 3", found, level_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (psel_o !== 1'b0 || penable_o !== 1'b0 || pwrite_o !== 1'b0)
      begin failures++; $display("FAIL rstmid_apb: psel=%b penable=%b pwrite=%b required 0 0 0", psel_o, penable_o, pwrite_o); end
    checks++; if (paddr_o !== 32'h0 || pwdata_o !== 32'h0)
      begin failures++; $display("FAIL rstmid_bus: addr=%h data=%h required 0 0", paddr_o, pwdata_o); end
    checks++; if (level_o !== '0 || busy_o !== 1'b0)
      begin failures++; $display("FAIL rstmid_level_busy: level=%0d busy=%b required 0 0", level_o, busy_o); end
    checks++; if (byte_ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b required 1", byte_ready_o); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (psel_o !== 1'b0) psel_seen++;
    end
    checks++; if (psel_seen != 0 || console_log.size() != 0)
      begin failures++; $display("FAIL rstmid_quiet: psel cycles=%0d writes=%0d required 0 0", psel_seen, console_log.size()); end
    tick();
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h5A;
    tick();
    byte_valid_i = 1'b0;
    drain("rstmid");
    checks++; if (console_log.size() != 1 || console_log[0] !== 8'h5A)
      begin failures++; $display("FAIL rstmid_resume: count=%0d required 1 byte 5a", console_log.size()); end
  endtask

  task automatic test_random();
    clear_logs();
    tick();
    for (int c = 0; c < 400; c++) begin
      byte_valid_i = ($urandom_range(0, 99) < 60);
      byte_data_i  = 8'($urandom);
      pready_i     = ($urandom_range(0, 99) < 65);
      @(negedge clk);
      checks++; if (level_o !== LW'(exp_q.size()))
        begin failures++; $display("FAIL rand_level: got %0d required %0d", level_o, exp_q.size()); end
      checks++; if (busy_o !== (exp_q.size() != 0))
        begin failures++; $display("FAIL rand_busy: got %b with %0d queued", busy_o, exp_q.size()); end
      checks++; if (byte_ready_o !== (exp_q.size() < DEPTH))
        begin failures++; $display("FAIL rand_ready: got %b with %0d queued", byte_ready_o, exp_q.size()); end
      if (psel_o === 1'b1) begin
        checks++; if (paddr_o !== ADDR || pwrite_o !== 1'b1)
          begin failures++; $display("FAIL rand_addr: addr=%h pwrite=%b required %h 1", paddr_o, pwrite_o, ADDR); end
        checks++; if (exp_q.size() == 0 || pwdata_o !== {24'h0, exp_q[0]})
          begin failures++; $display("FAIL rand_data: got %h with %0d queued", pwdata_o, exp_q.size()); end
      end else begin
        checks++; if (paddr_o !== 32'h0 || pwdata_o !== 32'h0 || penable_o !== 1'b0 || pwrite_o !== 1'b0)
          begin failures++; $display("FAIL rand_idle_bus: addr=%h data=%h penable=%b required zeros", paddr_o, pwdata_o, penable_o); end
      end
      tick();
    end
    byte_valid_i = 1'b0;
    pready_i     = 1'b1;
    drain("rand");
    checks++; if (console_log.size() != acc_log.size())
      begin failures++; $display("FAIL rand_count: got %0d required %0d", console_log.size(), acc_log.size()); end
    for (int k = 0; k < acc_log.size() && k < console_log.size(); k++) begin
      checks++; if (console_log[k] !== acc_log[k])
        begin failures++; $display("FAIL rand_order%0d: got %h required %h", k, console_log[k], acc_log[k]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    pready_i     = 1'b0;
    test_reset();
    test_single();
    test_hello();
`ifdef APB_CONSOLE_PREADY_EN
    test_wait_states();
`else
    test_pready_ignored();
`endif
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
